// File: rtl/miner_job_link.sv
`default_nettype none
// ============================================================================
// Module      : miner_job_link
// Description : Host byte-stream endpoint that loads one miner job frame,
//               launches the miner and returns a 6-byte result frame.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_job_link #(
   parameter logic [7:0] HDR_JOB   = 8'hA5,
   parameter logic [7:0] HDR_RESP  = 8'h5A,
   parameter logic [7:0] CMD_ABORT = 8'hC3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_data,
   output logic         rx_ready,
   output logic         tx_valid,
   output logic [7:0]   tx_data,
   input  logic         tx_ready,
   output logic         job_valid,
   output logic [95:0]  job_data,
   output logic [255:0] job_state,
   output logic [31:0]  job_nonce_base,
   output logic [255:0] job_target,
   input  logic         res_valid,
   input  logic [31:0]  res_nonce,
   input  logic         res_exhausted,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_LAUNCH = 3'd2,
      S_BUSY   = 3'd3,
      S_SEND   = 3'd4
   } state_t;

   localparam logic [6:0] LAST_PAYLOAD = 7'd79;
   localparam logic [6:0] LAST_RESP    = 7'd5;

   state_t         state_q, state_d;
   logic [6:0]     cnt_q, cnt_d;
   logic           rx_ready_q, rx_ready_d;
   logic           tx_valid_q, tx_valid_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           job_valid_q, job_valid_d;
   logic           busy_q, busy_d;
   logic [95:0]    job_data_q, job_data_d;
   logic [255:0]   job_state_q, job_state_d;
   logic [31:0]    nonce_base_q, nonce_base_d;
   logic [255:0]   target_q, target_d;
   logic [31:0]    nonce_q, nonce_d;
   logic           status_q, status_d;
   logic           exh_q;

   logic           rx_acc;
   logic           exh_rise;

   assign rx_acc   = rx_valid && rx_ready_q;
   assign exh_rise = res_exhausted && !exh_q;

   function automatic logic [7:0] resp_byte(input logic [6:0] idx, input logic st,
                                            input logic [31:0] n);
      logic [7:0] b;
      case (idx)
         7'd0:    b = HDR_RESP;
         7'd1:    b = {7'd0, st};
         7'd2:    b = n[7:0];
         7'd3:    b = n[15:8];
         7'd4:    b = n[23:16];
         7'd5:    b = n[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      job_valid_d  = 1'b0;
      busy_d       = busy_q;
      job_data_d   = job_data_q;
      job_state_d  = job_state_q;
      nonce_base_d = nonce_base_q;
      target_d     = target_q;
      nonce_d      = nonce_q;
      status_d     = status_q;

      case (state_q)
         S_IDLE: begin
            if (rx_acc && rx_data == HDR_JOB) begin
               state_d = S_LOAD;
               cnt_d   = 7'd0;
            end
         end
         S_LOAD: begin
            if (rx_acc) begin
               // Payload offset selects exactly one field byte; the rest hold.
               for (int i = 0; i < 12; i++)
                  if (cnt_q == 7'(i)) job_data_d[8*i +: 8] = rx_data;
               for (int i = 0; i < 32; i++)
                  if (cnt_q == 7'(i + 12)) job_state_d[8*i +: 8] = rx_data;
               for (int i = 0; i < 4; i++)
                  if (cnt_q == 7'(i + 44)) nonce_base_d[8*i +: 8] = rx_data;
               for (int i = 0; i < 32; i++)
                  if (cnt_q == 7'(i + 48)) target_d[8*i +: 8] = rx_data;
               if (cnt_q == LAST_PAYLOAD) begin
                  state_d     = S_LAUNCH;
                  job_valid_d = 1'b1;
                  busy_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         S_LAUNCH: begin
            state_d = S_BUSY;
         end
         S_BUSY: begin
            // Priority: found, then exhausted edge, then abort.
            if (res_valid || exh_rise) begin
               nonce_d    = res_valid ? res_nonce : 32'd0;
               status_d   = res_valid;
               state_d    = S_SEND;
               cnt_d      = 7'd0;
               tx_valid_d = 1'b1;
               tx_data_d  = HDR_RESP;
            end else if (rx_acc && rx_data == CMD_ABORT) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_SEND: begin
            if (tx_valid_q && tx_ready) begin
               if (cnt_q == LAST_RESP) begin
                  state_d    = S_IDLE;
                  tx_valid_d = 1'b0;
                  tx_data_d  = 8'h00;
                  busy_d     = 1'b0;
               end else begin
                  cnt_d     = cnt_q + 7'd1;
                  tx_data_d = resp_byte(cnt_q + 7'd1, status_q, nonce_q);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rx_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_BUSY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 7'd0;
         rx_ready_q   <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         job_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         job_data_q   <= '0;
         job_state_q  <= '0;
         nonce_base_q <= '0;
         target_q     <= '0;
         nonce_q      <= '0;
         status_q     <= 1'b0;
         exh_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rx_ready_q   <= rx_ready_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         job_valid_q  <= job_valid_d;
         busy_q       <= busy_d;
         job_data_q   <= job_data_d;
         job_state_q  <= job_state_d;
         nonce_base_q <= nonce_base_d;
         target_q     <= target_d;
         nonce_q      <= nonce_d;
         status_q     <= status_d;
         exh_q        <= res_exhausted;
      end
   end

   assign rx_ready       = rx_ready_q;
   assign tx_valid       = tx_valid_q;
   assign tx_data        = tx_data_q;
   assign job_valid      = job_valid_q;
   assign busy           = busy_q;
   assign job_data       = job_data_q;
   assign job_state      = job_state_q;
   assign job_nonce_base = nonce_base_q;
   assign job_target     = target_q;

endmodule
`default_nettype wire

// File: tb/tb_miner_job_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_miner_job_link
// Description : Self-checking bench for miner_job_link against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miner_job_link;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_ready;
   logic         tx_valid;
   logic [7:0]   tx_data;
   logic         tx_ready = 1'b0;
   logic         job_valid;
   logic [95:0]  job_data;
   logic [255:0] job_state;
   logic [31:0]  job_nonce_base;
   logic [255:0] job_target;
   logic         res_valid = 1'b0;
   logic [31:0]  res_nonce = 32'h0;
   logic         res_exhausted = 1'b0;
   logic         busy;

   int checks   = 0;
   int failures = 0;
   logic [7:0] pay [80];

   always #5 clk = ~clk;

   miner_job_link dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .job_valid(job_valid), .job_data(job_data), .job_state(job_state),
      .job_nonce_base(job_nonce_base), .job_target(job_target),
      .res_valid(res_valid), .res_nonce(res_nonce), .res_exhausted(res_exhausted),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   n = 0;
      logic took = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!took && n < 50) begin
         took = rx_ready;
         tick();
         n++;
      end
      rx_valid = 1'b0;
      checks++;
      if (took !== 1'b1) begin
         failures++;
         $display("FAIL send_byte_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
      end
   endtask

   task automatic gen_payload(input logic [31:0] nb);
      for (int k = 0; k < 80; k++) pay[k] = 8'($urandom);
      for (int k = 0; k < 4; k++) pay[44+k] = nb[8*k +: 8];
   endtask

   task automatic send_frame();
      send_byte(8'hA5);
      for (int k = 0; k < 80; k++) send_byte(pay[k]);
   endtask

   task automatic check_fields(input string name);
      logic [95:0]  ed;
      logic [255:0] es, et;
      logic [31:0]  eb;
      for (int k = 0; k < 12; k++) ed[8*k +: 8] = pay[k];
      for (int k = 0; k < 32; k++) es[8*k +: 8] = pay[12+k];
      for (int k = 0; k < 32; k++) et[8*k +: 8] = pay[48+k];
      eb = {pay[47], pay[46], pay[45], pay[44]};
      checks++;
      if (job_data !== ed || job_state !== es || job_nonce_base !== eb || job_target !== et) begin
         failures++;
         $display("FAIL %s_fields data=%h/%h nonce_base=%h/%h state_ok=%b target_ok=%b",
                  name, job_data, ed, job_nonce_base, eb, job_state === es, job_target === et);
      end
   endtask

   // Called right after byte 79 was accepted: launch pulse must be this cycle only.
   task automatic check_launch(input string name);
      checks++;
      if (job_valid !== 1'b1 || busy !== 1'b1 || rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_launch job_valid=%b busy=%b rx_ready=%b required 1 1 0",
                  name, job_valid, busy, rx_ready);
      end
      check_fields(name);
      tick();
      checks++;
      if (job_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_pulse_width job_valid=%b busy=%b required 0 1", name, job_valid, busy);
      end
   endtask

   task automatic fire_found(input logic [31:0] n);
      res_valid = 1'b1;
      res_nonce = n;
      tick();
      res_valid = 1'b0;
      res_nonce = 32'($urandom);
   endtask

   // Collects one result frame; exp packs the expected bytes with byte 0 lowest.
   task automatic recv_frame(input string name, input logic [47:0] exp,
                             input int stall_idx, input int stall_len, input bit rnd_bp);
      int         got = 0, cyc = 0, stall = 0;
      logic [7:0] rb [6];
      logic       prev_stall = 1'b0;
      logic [7:0] prev_d = 8'h00;
      logic       rdy;
      while (got < 6 && cyc < 300) begin
         if (prev_stall) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
               failures++;
               $display("FAIL %s_hold tx_valid=%b tx_data=%h required 1 %h",
                        name, tx_valid, tx_data, prev_d);
            end
         end
         if (got == stall_idx && stall < stall_len) begin
            rdy = 1'b0;
            stall++;
         end else if (rnd_bp) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         tx_ready = rdy;
         if (tx_valid === 1'b1 && rdy) begin
            rb[got]    = tx_data;
            got++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = (tx_valid === 1'b1);
         end
         prev_d = tx_data;
         tick();
         cyc++;
      end
      tx_ready = 1'b0;
      checks++;
      if (got != 6) begin
         failures++;
         $display("FAIL %s_frame_len got=%0d required 6", name, got);
      end
      for (int i = 0; i < got; i++) begin
         checks++;
         if (rb[i] !== exp[8*i +: 8]) begin
            failures++;
            $display("FAIL %s_byte%0d got=%h required %h", name, i, rb[i], exp[8*i +: 8]);
         end
      end
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_done tx_valid=%b busy=%b required 0 0", name, tx_valid, busy);
      end
   endtask

   task automatic check_all_reset(input string name);
      checks++;
      if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || job_valid !== 1'b0 ||
          busy !== 1'b0 || job_data !== '0 || job_state !== '0 || job_nonce_base !== '0 ||
          job_target !== '0) begin
         failures++;
         $display("FAIL %s rx_ready=%b tx_valid=%b tx_data=%h job_valid=%b busy=%b nb=%h required all 0",
                  name, rx_ready, tx_valid, tx_data, job_valid, busy, job_nonce_base);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_all_reset("reset_state");
      rst = 1'b0;
      tick();
      checks++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle_ready rx_ready=%b required 1", rx_ready);
      end
   endtask

   task automatic test_found();
      gen_payload(32'h0000_0010);
      send_frame();
      check_launch("found");
      repeat (3) tick();
      fire_found(32'h0000_0012);
      recv_frame("found", {32'h0000_0012, 8'h01, 8'h5A}, -1, 0, 1'b0);
      check_fields("found_stable");
   endtask

   task automatic test_junk();
      logic [31:0] n;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      res_valid = 1'b1;
      res_nonce = 32'hDEAD_BEEF;
      tick();
      res_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || job_valid !== 1'b0) begin
         failures++;
         $display("FAIL junk_idle busy=%b tx_valid=%b job_valid=%b required 0 0 0",
                  busy, tx_valid, job_valid);
      end
      gen_payload(32'($urandom));
      send_frame();
      check_launch("junk");
      send_byte(8'h00);
      send_byte(8'hA5);
      checks++;
      if (busy !== 1'b1 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL junk_busy_drop busy=%b tx_valid=%b required 1 0", busy, tx_valid);
      end
      n = 32'($urandom);
      fire_found(n);
      recv_frame("junk", {n, 8'h01, 8'h5A}, -1, 0, 1'b0);
   endtask

   task automatic test_exhausted();
      res_exhausted = 1'b0;
      gen_payload(32'($urandom));
      send_frame();
      check_launch("exh");
      tick();
      res_exhausted = 1'b1;
      tick();
      recv_frame("exh", {32'h0, 8'h00, 8'h5A}, -1, 0, 1'b0);
      gen_payload(32'($urandom));
      send_frame();
      check_launch("exh_level");
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL exh_level_quiet cyc=%0d tx_valid=%b busy=%b required 0 1",
                     i, tx_valid, busy);
         end
         tick();
      end
      res_exhausted = 1'b0;
      tick();
      fire_found(32'h0BAD_F00D);
      recv_frame("exh_level", {32'h0BAD_F00D, 8'h01, 8'h5A}, -1, 0, 1'b0);
   endtask

   task automatic test_abort();
      logic [31:0] n;
      gen_payload(32'($urandom));
      send_frame();
      check_launch("abort");
      send_byte(8'hC3);
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_stop busy=%b tx_valid=%b required 0 0", busy, tx_valid);
      end
      repeat (3) tick();
      checks++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_idle tx_valid=%b rx_ready=%b required 0 1", tx_valid, rx_ready);
      end
      gen_payload(32'($urandom));
      send_frame();
      check_launch("abort_next");
      n = 32'($urandom);
      fire_found(n);
      recv_frame("abort_next", {n, 8'h01, 8'h5A}, -1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [31:0] n;
      gen_payload(32'($urandom));
      send_frame();
      check_launch("bp");
      n = 32'h8877_6655;
      fire_found(n);
      recv_frame("bp", {n, 8'h01, 8'h5A}, 2, 5, 1'b0);
   endtask

   task automatic test_reset_midframe();
      logic [31:0] n;
      gen_payload(32'($urandom));
      send_byte(8'hA5);
      for (int k = 0; k <= 40; k++) send_byte(pay[k]);
      rst = 1'b1;
      tick();
      check_all_reset("midframe_reset");
      rst = 1'b0;
      tick();
      gen_payload(32'($urandom));
      send_frame();
      check_launch("midframe");
      n = 32'($urandom);
      fire_found(n);
      recv_frame("midframe", {n, 8'h01, 8'h5A}, -1, 0, 1'b1);
   endtask

   // Random jobs: found, exhausted, found+exhausted together, found+abort together.
   task automatic test_random();
      int          mode;
      logic [31:0] n;
      logic [47:0] exp;
      for (int j = 0; j < 8; j++) begin
         mode          = int'($urandom_range(0, 3));
         n             = 32'($urandom);
         res_exhausted = 1'b0;
         gen_payload(32'($urandom));
         send_frame();
         check_launch("rand");
         repeat ($urandom_range(0, 5)) tick();
         case (mode)
            0: begin
               fire_found(n);
               exp = {n, 8'h01, 8'h5A};
            end
            1: begin
               res_exhausted = 1'b1;
               tick();
               exp = {32'h0, 8'h00, 8'h5A};
            end
            2: begin
               res_exhausted = 1'b1;
               fire_found(n);
               exp = {n, 8'h01, 8'h5A};
            end
            default: begin
               rx_valid = 1'b1;
               rx_data  = 8'hC3;
               fire_found(n);
               rx_valid = 1'b0;
               exp = {n, 8'h01, 8'h5A};
            end
         endcase
         recv_frame("rand", exp, -1, 0, 1'b1);
         res_exhausted = 1'b0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_found();
      test_junk();
      test_exhausted();
      test_abort();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
